// File: rtl/btn_ctrl.sv
// Per-channel button front end: synchroniser, debouncer, edge pulses
// and a mode-selected enable register with synchronous clear.
module btn_ctrl #(
  parameter int N       = 4,
  parameter int DEB_MAX = 50000,
  parameter int CNT_W   = $clog2(DEB_MAX)
) (
  input  logic           mclk,
  input  logic           rst,
  input  logic [N-1:0]   btn,
  input  logic [N-1:0]   clr,
  input  logic [2*N-1:0] mode,
  output logic [N-1:0]   en,
  output logic [N-1:0]   press_p,
  output logic [N-1:0]   rel_p,
  output logic [N-1:0]   stable
);

  localparam logic [1:0] M_TREL  = 2'b00;
  localparam logic [1:0] M_TPRS  = 2'b01;
  localparam logic [1:0] M_LEVEL = 2'b10;
  localparam logic [1:0] M_ONE   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEB_MAX - 1);

  logic [N-1:0]     r_s1;
  logic [N-1:0]     r_s2;
  logic [CNT_W-1:0] r_cnt [N];

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      stable  <= '0;
      press_p <= '0;
      rel_p   <= '0;
      en      <= '0;
      for (int i = 0; i < N; i++)
        r_cnt[i] <= '0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
      for (int i = 0; i < N; i++) begin
        press_p[i] <= 1'b0;
        rel_p[i]   <= 1'b0;
        if (r_s2[i] == stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_TOP) begin
          stable[i]  <= r_s2[i];
          press_p[i] <= r_s2[i];
          rel_p[i]   <= ~r_s2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
        // enable reacts to last cycle's registered pulses/level
        if (clr[i]) begin
          en[i] <= 1'b0;
        end else begin
          unique case (mode[2*i +: 2])
            M_TREL:  en[i] <= rel_p[i] ? ~en[i] : en[i];
            M_TPRS:  en[i] <= press_p[i] ? ~en[i] : en[i];
            M_LEVEL: en[i] <= stable[i];
            M_ONE:   en[i] <= rel_p[i];
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_ctrl.sv
// Bench for btn_ctrl: directed scenarios then random traffic,
// all checked against a window-based behavioural model.
module tb_btn_ctrl;

  localparam int N  = 2;
  localparam int DM = 4;

  logic       mclk;
  logic       rst;
  logic [1:0] btn;
  logic [1:0] clr;
  logic [3:0] mode;
  logic [1:0] en;
  logic [1:0] press_p;
  logic [1:0] rel_p;
  logic [1:0] stable;

  int ncmp  = 0;
  int nfail = 0;

  btn_ctrl #(.N(N), .DEB_MAX(DM)) dut (
    .mclk(mclk), .rst(rst), .btn(btn), .clr(clr),
    .mode(mode), .en(en), .press_p(press_p),
    .rel_p(rel_p), .stable(stable)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // model state
  logic [1:0] m_d1, m_d2, m_st, m_pr, m_rl, m_en;
  logic [1:0] hist [$];
  int         ecount;
  int         lastchg [2];

  task automatic chk(input string tag, input logic [1:0] obs,
                     input logic [1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [1:0] s2pre, nst, npr, nrl, nen;
    bit         ok;
    @(posedge mclk);
    ecount++;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_st = '0;
      m_pr = '0; m_rl = '0; m_en = '0;
      hist.push_back(2'b00);
      for (int ch = 0; ch < N; ch++) lastchg[ch] = ecount;
    end else begin
      s2pre = m_d2;
      m_d2  = m_d1;
      m_d1  = btn;
      hist.push_back(s2pre);
      nst = m_st; npr = '0; nrl = '0; nen = m_en;
      for (int ch = 0; ch < N; ch++) begin
        // accept after DM straight samples disagreeing with stable
        ok = 1'b0;
        if (ecount - lastchg[ch] >= DM) begin
          ok = 1'b1;
          for (int j = 0; j < DM; j++)
            if (hist[hist.size()-1-j][ch] == m_st[ch]) ok = 1'b0;
        end
        if (ok) begin
          nst[ch] = ~m_st[ch];
          npr[ch] = nst[ch];
          nrl[ch] = ~nst[ch];
          lastchg[ch] = ecount;
        end
        if (clr[ch]) nen[ch] = 1'b0;
        else begin
          case (mode[2*ch +: 2])
            2'b00:   nen[ch] = m_en[ch] ^ m_rl[ch];
            2'b01:   nen[ch] = m_en[ch] ^ m_pr[ch];
            2'b10:   nen[ch] = m_st[ch];
            default: nen[ch] = m_rl[ch];
          endcase
        end
      end
      m_st = nst; m_pr = npr; m_rl = nrl; m_en = nen;
    end
    #1;
    chk("stable", stable, m_st);
    chk("press_p", press_p, m_pr);
    chk("rel_p", rel_p, m_rl);
    chk("en", en, m_en);
  endtask

  initial begin
    ecount = 0;
    lastchg[0] = 0; lastchg[1] = 0;
    m_d1 = '0; m_d2 = '0; m_st = '0;
    m_pr = '0; m_rl = '0; m_en = '0;
    rst = 1'b1; btn = '0; clr = '0; mode = '0;
    repeat (3) tick();
    chk("rst_stable", stable, 2'b00);
    chk("rst_en", en, 2'b00);
    rst = 1'b0;
    repeat (2) tick();

    // press latency and pulse width
    btn[0] = 1'b1;
    repeat (5) tick();
    chk("deb_early", {1'b0, stable[0]}, 2'b00);
    tick();
    chk("deb_edge", {1'b0, stable[0]}, 2'b01);
    chk("press_hi", {1'b0, press_p[0]}, 2'b01);
    tick();
    chk("press_lo", {1'b0, press_p[0]}, 2'b00);
    chk("en_hold", {1'b0, en[0]}, 2'b00);

    // release toggles in mode 00, second cycle toggles back
    btn[0] = 1'b0;
    repeat (6) tick();
    chk("rel_hi", {1'b0, rel_p[0]}, 2'b01);
    tick();
    chk("en_tog1", {1'b0, en[0]}, 2'b01);
    btn[0] = 1'b1;
    repeat (8) tick();
    btn[0] = 1'b0;
    repeat (8) tick();
    chk("en_tog2", {1'b0, en[0]}, 2'b00);

    // bounce on channel 1 must be rejected
    foreach (hist[k]) begin end
    for (int k = 0; k < 8; k++) begin
      btn[1] = (k % 4) < 2;
      tick();
    end
    btn[1] = 1'b0;
    repeat (6) tick();
    chk("bounce_st", {1'b0, stable[1]}, 2'b00);
    chk("bounce_en", {1'b0, en[1]}, 2'b00);

    // clear beats a toggle
    btn[0] = 1'b1;
    repeat (8) tick();
    btn[0] = 1'b0;
    repeat (6) tick();
    chk("clr_rel", {1'b0, rel_p[0]}, 2'b01);
    clr[0] = 1'b1;
    tick();
    chk("clr_win", {1'b0, en[0]}, 2'b00);
    clr[0] = 1'b0;
    tick();

    // oneshot on channel 1
    mode[3:2] = 2'b11;
    btn[1] = 1'b1;
    repeat (8) tick();
    btn[1] = 1'b0;
    repeat (6) tick();
    chk("one_rel", {1'b0, rel_p[1]}, 2'b01);
    chk("one_pre", {1'b0, en[1]}, 2'b00);
    tick();
    chk("one_hi", {1'b0, en[1]}, 2'b01);
    tick();
    chk("one_lo", {1'b0, en[1]}, 2'b00);

    // level mode tracks stable one cycle later
    mode[3:2] = 2'b10;
    btn[1] = 1'b1;
    repeat (6) tick();
    chk("lvl_st", {1'b0, stable[1]}, 2'b01);
    chk("lvl_lag", {1'b0, en[1]}, 2'b00);
    tick();
    chk("lvl_hi", {1'b0, en[1]}, 2'b01);
    btn[1] = 1'b0;
    repeat (7) tick();
    chk("lvl_lo", {1'b0, en[1]}, 2'b00);

    // reset mid-count discards progress
    mode = '0;
    btn[0] = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("mrst_st", stable, 2'b00);
    chk("mrst_pr", press_p, 2'b00);
    chk("mrst_en", en, 2'b00);
    rst = 1'b0;
    repeat (5) tick();
    chk("mrst_early", {1'b0, stable[0]}, 2'b00);
    tick();
    chk("mrst_acc", {1'b0, stable[0]}, 2'b01);
    chk("mrst_press", {1'b0, press_p[0]}, 2'b01);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0)
        btn[$urandom_range(0, 1)] ^= 1'b1;
      clr[0] = ($urandom_range(0, 7) == 0);
      clr[1] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) mode = 4'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/btn_ctrl.md
BTN_CTRL -- requirements
Module: btn_ctrl

Interface
REQ-001 Parameter: N, default 4, number of independent button channels (1..16).
REQ-002 Parameter: DEB_MAX, default 50000, number of consecutive stable cycles required to accept a level change (minimum 2).
REQ-003 Parameter: CNT_W, default $clog2(DEB_MAX), width of each debounce counter.
REQ-004 Port: mclk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: btn  input  N  raw, asynchronous, bouncing button levels; 1 = pressed.
REQ-007 Port: clr  input  N  per-channel synchronous clear of en; sampled directly without debouncing.
REQ-008 Port: mode  input  2*N  per-channel mode; bits [2i+1:2i] select the mode of channel i.
REQ-009 Port: en  output  N  registered per-channel enable.
REQ-010 Port: press_p  output  N  one-cycle pulse on each accepted press (debounced 0->1).
REQ-011 Port: rel_p  output  N  one-cycle pulse on each accepted release (debounced 1->0).
REQ-012 Port: stable  output  N  debounced button level.

Function
REQ-013 Each btn bit SHALL pass through a 2-flop synchroniser (s1, s2) before any other use.
REQ-014 Debounce per channel, evaluated every edge, SHALL work as follows:
- if s2 == stable, cnt <= 0
- else if cnt == DEB_MAX-1, stable <= s2 and cnt <= 0
- else cnt <= cnt+1
REQ-015 Debounce latency: if btn changes before edge k and is held, stable SHALL change at edge k+DEB_MAX+1.
REQ-016 Any glitch shorter than DEB_MAX cycles at s2 SHALL reset cnt and leave stable unchanged.
REQ-017 press_p[i] / rel_p[i] SHALL be registered and high for exactly the one cycle in which stable[i] first shows its new value 1 / 0.
REQ-018 en[i] SHALL update on the edge after a pulse, per mode[i]:
- 00 TOGGLE_REL: invert en on rel_p.
- 01 TOGGLE_PRESS: invert en on press_p.
- 10 LEVEL: en <= stable.
- 11 ONESHOT: en <= rel_p (one-cycle pulse, one cycle after rel_p).
REQ-019 clr[i] high SHALL force en[i] <= 0 on that edge and SHALL take priority over any simultaneous toggle, level or oneshot update.
REQ-020 clr SHALL NOT affect s1, s2, cnt, stable, press_p or rel_p.
REQ-021 A mode change SHALL take effect on the next edge without resetting any state:
- into TOGGLE_REL or TOGGLE_PRESS: en holds its current value.
- into LEVEL: en takes stable.
- into ONESHOT: en clears unless rel_p is high.
REQ-022 Channels SHALL be fully independent; events on all N channels in the same cycle SHALL each be processed.
REQ-023 cnt SHALL never exceed DEB_MAX-1 and SHALL never wrap.

Reset
REQ-024 While rst is high on an edge, s1, s2, cnt, stable, press_p, rel_p and en SHALL all be cleared to 0, overriding clr and mode.
REQ-025 After rst deasserts with btn held at 1, the block SHALL see this as a press: stable goes 1 after DEB_MAX+2 edges and press_p fires.
REQ-026 Reset mid-debounce SHALL discard the partial count.

Verification (N=2, DEB_MAX=4)
REQ-027 btn[0] 0->1 before edge 10 and held, mode=00 -> stable[0]=1 and press_p[0]=1 after edge 15, press_p low after edge 16, en[0] stays 0.
REQ-028 Then btn[0] 1->0 and held, mode=00 -> rel_p[0] pulse, then en[0]=1; a second full press/release -> en[0]=0.
REQ-029 btn[1] bounces 1,0,1,0 with each level held 2 cycles -> stable[1], press_p[1] and en[1] unchanged.
REQ-030 clr[0]=1 on the same edge en[0] would toggle 0->1 -> en[0]=0.
REQ-031 mode=11 on channel 1 with a clean press/release -> en[1] high exactly one cycle, the cycle after rel_p[1]; mode=10 -> en[1] tracks stable[1].
REQ-032 rst pulsed while cnt[0]=2 -> all outputs 0 on the next cycle; the count restarts from 0.
